// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, the 16-bit
// instruction type, the default bubble instruction and the PC+2 helper.
package fetch_pkg;

  typedef logic [15:0] instr_t;

  localparam instr_t NOP_INSTR_DEFAULT = 16'h0800;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    SKID  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Address of the next sequential instruction; wraps modulo 2^16.
  function automatic logic [15:0] pc_inc2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pcinc} holding buffer used when a fetch completes while
// decode is stalled. Only the occupancy bit is reset; the payload is
// qualified by it.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  instr_t      instr_in,
  input  logic [15:0] pcinc_in,
  output instr_t      instr,
  output logic        valid,
  output logic [15:0] pcinc
);

  logic        valid_q, valid_d;
  instr_t      instr_q, instr_d;
  logic [15:0] pcinc_q, pcinc_d;

  // Next-state: clear wins, then load, then unload.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pcinc_d = pcinc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pcinc_d = pcinc_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Occupancy register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Payload registers, meaningful only while valid_q is set.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pcinc_q <= pcinc_d;
  end

  assign instr = instr_q;
  assign pcinc = pcinc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: memory read handshake, IF/ID register, skid
// buffer for decode stalls, and the PC hold feedback.
// Optional misaligned-fetch check enabled by FETCH_ALIGN_CHK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  input  logic [15:0] ImemData,
  input  logic        ImemDone,
  input  logic        ImemStall,
  input  logic        IdStall,
  input  logic        Flush,
  output logic [15:0] ImemAddr,
  output logic        ImemRd,
  output logic [15:0] IfIdInstr,
  output logic [15:0] IfIdPcInc,
  output logic        IfIdValid,
  output logic        PcHold,
  output logic        Err
);

  fetch_state_e state_q, state_d;
  instr_t       instr_q, instr_d;
  logic [15:0]  pcinc_q, pcinc_d;
  logic         valid_q, valid_d;

  logic         skid_load, skid_unload, skid_clear;
  instr_t       skid_instr;
  logic [15:0]  skid_pcinc;
  logic         skid_valid;

  logic         deliver;
  logic         align_bad;
  logic [15:0]  pc_next;

  assign pc_next  = pc_inc2(PC);
  assign ImemAddr = PC;

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q, err_d;

  assign align_bad = (state_q == REQ) && PC[0];

  // Sticky misalignment flag, cleared only by reset.
  always_comb err_d = err_q | align_bad;

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign Err = err_q;
`else
  assign align_bad = 1'b0;
  assign Err       = 1'b0;
`endif

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .instr_in (ImemData),
    .pcinc_in (pc_next),
    .instr    (skid_instr),
    .valid    (skid_valid),
    .pcinc    (skid_pcinc)
  );

  // FSM next state, IF/ID next value, skid controls and memory/PC handshake.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pcinc_d     = pcinc_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    deliver     = 1'b0;
    ImemRd      = 1'b0;
    PcHold      = 1'b1;

    case (state_q)
      REQ: begin
        ImemRd = 1'b1;
        if (align_bad) begin
          ImemRd  = 1'b0;
          instr_d = NOP_INSTR;
          pcinc_d = 16'h0000;
          valid_d = 1'b0;
        end else if (!ImemStall) begin
          if (ImemDone) deliver = 1'b1;
          else          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ImemDone) begin
          deliver = 1'b1;
          state_d = REQ;
        end
      end
      SKID: begin
        if (!IdStall) begin
          instr_d     = skid_instr;
          pcinc_d     = skid_pcinc;
          valid_d     = skid_valid;
          skid_unload = 1'b1;
          state_d     = REQ;
        end
      end
      DRAIN: begin
        // The redirected-away response is dropped when it arrives.
        if (ImemDone) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // A returned instruction goes straight to decode if the IF/ID slot is
    // free or draining this cycle, otherwise it is parked in the skid entry.
    if (deliver) begin
      PcHold = 1'b0;
      if (!valid_q || !IdStall) begin
        instr_d = ImemData;
        pcinc_d = pc_next;
        valid_d = 1'b1;
      end else begin
        skid_load = 1'b1;
        state_d   = SKID;
      end
    end

    // A redirect discards everything in flight. A request still outstanding
    // in WAIT (or DRAIN) must have its response swallowed before refetching.
    if (Flush) begin
      instr_d     = NOP_INSTR;
      pcinc_d     = 16'h0000;
      valid_d     = 1'b0;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b1;
      PcHold      = 1'b1;
      if ((state_q == WAIT || state_q == DRAIN) && !ImemDone) state_d = DRAIN;
      else                                                    state_d = REQ;
    end

    if (rst) begin
      ImemRd = 1'b0;
      PcHold = 1'b1;
    end
  end

  // FSM state and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      instr_q <= NOP_INSTR;
      pcinc_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pcinc_q <= pcinc_d;
      valid_q <= valid_d;
    end
  end

  assign IfIdInstr = instr_q;
  assign IfIdPcInc = pcinc_q;
  assign IfIdValid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors covering
// single-cycle and multi-cycle memory, skid, flush and PC wrap, plus
// hand-written reset and misalignment sequences (FETCH_ALIGN_CHK_EN aware).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] PC;
  logic [15:0] ImemData;
  logic        ImemDone;
  logic        ImemStall;
  logic        IdStall;
  logic        Flush;
  logic [15:0] ImemAddr;
  logic        ImemRd;
  logic [15:0] IfIdInstr;
  logic [15:0] IfIdPcInc;
  logic        IfIdValid;
  logic        PcHold;
  logic        Err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PC        (PC),
    .ImemData  (ImemData),
    .ImemDone  (ImemDone),
    .ImemStall (ImemStall),
    .IdStall   (IdStall),
    .Flush     (Flush),
    .ImemAddr  (ImemAddr),
    .ImemRd    (ImemRd),
    .IfIdInstr (IfIdInstr),
    .IfIdPcInc (IfIdPcInc),
    .IfIdValid (IfIdValid),
    .PcHold    (PcHold),
    .Err       (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
    logic        done;
    logic        mstall;
    logic        ids;
    logic        flush;
    logic        rd;
    logic        hold;
    logic [15:0] instr;
    logic [15:0] pcinc;
    logic        valid;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t v(input logic [15:0] pc, input logic [15:0] data,
                             input logic done, input logic mstall,
                             input logic ids, input logic flush,
                             input logic rd, input logic hold,
                             input logic [15:0] instr, input logic [15:0] pcinc,
                             input logic valid);
    vec_t r;
    r.pc = pc; r.data = data; r.done = done; r.mstall = mstall;
    r.ids = ids; r.flush = flush; r.rd = rd; r.hold = hold;
    r.instr = instr; r.pcinc = pcinc; r.valid = valid;
    return r;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] data,
                       input logic done, input logic mstall,
                       input logic ids, input logic flush);
    PC = pc; ImemData = data; ImemDone = done;
    ImemStall = mstall; IdStall = ids; Flush = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pc     data     dn ms id fl   rd hold instr    pcinc    vl
    // single-cycle memory, PC = 0,2,4
    tbl[0]  = v(16'h0000, 16'hA000, 1, 0, 0, 0,  1, 0, 16'hA000, 16'h0002, 1);
    tbl[1]  = v(16'h0002, 16'hA002, 1, 0, 0, 0,  1, 0, 16'hA002, 16'h0004, 1);
    tbl[2]  = v(16'h0004, 16'hA004, 1, 0, 0, 0,  1, 0, 16'hA004, 16'h0006, 1);
    // 3-cycle memory at 0x0010
    tbl[3]  = v(16'h0010, 16'h0000, 0, 0, 0, 0,  1, 1, 16'hA004, 16'h0006, 1);
    tbl[4]  = v(16'h0010, 16'h0000, 0, 0, 0, 0,  0, 1, 16'hA004, 16'h0006, 1);
    tbl[5]  = v(16'h0010, 16'h1234, 1, 0, 0, 0,  0, 0, 16'h1234, 16'h0012, 1);
    // memory refuses, then accepts
    tbl[6]  = v(16'h0012, 16'h0000, 0, 1, 0, 0,  1, 1, 16'h1234, 16'h0012, 1);
    tbl[7]  = v(16'h0012, 16'hB012, 1, 0, 0, 0,  1, 0, 16'hB012, 16'h0014, 1);
    // decode stall for 3 cycles while a fetch completes
    tbl[8]  = v(16'h0014, 16'hC014, 1, 0, 1, 0,  1, 0, 16'hB012, 16'h0014, 1);
    tbl[9]  = v(16'h0016, 16'h0000, 0, 0, 1, 0,  0, 1, 16'hB012, 16'h0014, 1);
    tbl[10] = v(16'h0016, 16'h0000, 0, 0, 1, 0,  0, 1, 16'hB012, 16'h0014, 1);
    tbl[11] = v(16'h0016, 16'h0000, 0, 0, 0, 0,  0, 1, 16'hC014, 16'h0016, 1);
    tbl[12] = v(16'h0016, 16'hD016, 1, 0, 0, 0,  1, 0, 16'hD016, 16'h0018, 1);
    // flush during WAIT, late response 0xDEAD discarded
    tbl[13] = v(16'h0018, 16'h0000, 0, 0, 0, 0,  1, 1, 16'hD016, 16'h0018, 1);
    tbl[14] = v(16'h0018, 16'h0000, 0, 0, 0, 1,  0, 1, 16'h0800, 16'h0000, 0);
    tbl[15] = v(16'h0040, 16'h0000, 0, 0, 0, 0,  0, 1, 16'h0800, 16'h0000, 0);
    tbl[16] = v(16'h0040, 16'hDEAD, 1, 0, 0, 0,  0, 1, 16'h0800, 16'h0000, 0);
    tbl[17] = v(16'h0040, 16'hE040, 1, 0, 0, 0,  1, 0, 16'hE040, 16'h0042, 1);
    // PC wrap
    tbl[18] = v(16'hFFFE, 16'hF0FE, 1, 0, 0, 0,  1, 0, 16'hF0FE, 16'h0000, 1);
    // flush in REQ overrides a same-cycle completion
    tbl[19] = v(16'h0000, 16'h1111, 1, 0, 0, 1,  1, 1, 16'h0800, 16'h0000, 0);
    // flush while parked in SKID clears the skid entry
    tbl[20] = v(16'h0000, 16'h2222, 1, 0, 0, 0,  1, 0, 16'h2222, 16'h0002, 1);
    tbl[21] = v(16'h0002, 16'h3333, 1, 0, 1, 0,  1, 0, 16'h2222, 16'h0002, 1);
    tbl[22] = v(16'h0004, 16'h0000, 0, 0, 1, 1,  0, 1, 16'h0800, 16'h0000, 0);
    tbl[23] = v(16'h0004, 16'h4444, 1, 0, 0, 0,  1, 0, 16'h4444, 16'h0006, 1);
    // empty IF/ID accepts even with decode stalled
    tbl[24] = v(16'h0006, 16'h0000, 0, 0, 0, 1,  1, 1, 16'h0800, 16'h0000, 0);
    tbl[25] = v(16'h0006, 16'h5555, 1, 0, 1, 0,  1, 0, 16'h5555, 16'h0008, 1);

    // Reset held: outputs at reset values.
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd",    0, {15'd0, ImemRd},    16'h0000);
    chk("rst_hold",  0, {15'd0, PcHold},    16'h0001);
    chk("rst_instr", 0, IfIdInstr,          16'h0800);
    chk("rst_pcinc", 0, IfIdPcInc,          16'h0000);
    chk("rst_valid", 0, {15'd0, IfIdValid}, 16'h0000);
    chk("rst_err",   0, {15'd0, Err},       16'h0000);
    rst = 1'b0;

    // Table-driven per-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].pc, tbl[i].data, tbl[i].done, tbl[i].mstall,
            tbl[i].ids, tbl[i].flush);
      #1;
      chk("addr",  i, ImemAddr,            tbl[i].pc);
      chk("rd",    i, {15'd0, ImemRd},     {15'd0, tbl[i].rd});
      chk("hold",  i, {15'd0, PcHold},     {15'd0, tbl[i].hold});
      tick();
      chk("instr", i, IfIdInstr,           tbl[i].instr);
      chk("pcinc", i, IfIdPcInc,           tbl[i].pcinc);
      chk("valid", i, {15'd0, IfIdValid},  {15'd0, tbl[i].valid});
    end

    // Reset in the middle of a fetch: back in REQ, no drain.
    drive(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();                              // REQ -> WAIT
    #1;
    chk("mid_wait_rd", 0, {15'd0, ImemRd}, 16'h0000);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 0, {15'd0, IfIdValid}, 16'h0000);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_rd", 0, {15'd0, ImemRd}, 16'h0001);
    drive(16'h0020, 16'h6020, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_rel_hold", 0, {15'd0, PcHold}, 16'h0000);
    tick();
    chk("mid_rel_instr", 0, IfIdInstr, 16'h6020);

    // Misaligned PC.
    drive(16'h0003, 16'h7003, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_rd",   0, {15'd0, ImemRd}, 16'h0000);
    chk("mis_hold", 0, {15'd0, PcHold}, 16'h0001);
    tick();
    chk("mis_err",   0, {15'd0, Err},       16'h0001);
    chk("mis_valid", 0, {15'd0, IfIdValid}, 16'h0000);
    chk("mis_instr", 0, IfIdInstr,          16'h0800);
    drive(16'h0004, 16'h7004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis_sticky", 0, {15'd0, Err}, 16'h0001);
    chk("mis_next",   0, IfIdInstr,    16'h7004);
    rst = 1'b1;
    #1;
    chk("mis_rst_err", 0, {15'd0, Err}, 16'h0000);
    tick();
    rst = 1'b0;
`else
    chk("mis_rd",   0, {15'd0, ImemRd}, 16'h0001);
    tick();
    chk("mis_err",   0, {15'd0, Err}, 16'h0000);
    chk("mis_instr", 0, IfIdInstr,    16'h7003);
    chk("mis_pcinc", 0, IfIdPcInc,    16'h0005);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly downstream of the program-counter block. Takes the current PC, runs the read handshake with a multi-cycle instruction memory and loads the IF/ID pipeline register consumed by decode. Returns a hold signal to the PC block (driven into its `Halt` input) so the PC only advances when an instruction has been accepted. Includes a one-entry skid buffer so a fetch completing under a decode stall is not lost.

## Interface
Parameters:
- `NOP_INSTR`, default 16'h0800: bubble instruction loaded on reset or flush.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PC`  in  16  current PC from the PC block, the address being fetched.
- `ImemData`  in  16  read data from instruction memory.
- `ImemDone`  in  1  `ImemData` valid this cycle.
- `ImemStall`  in  1  memory refused this cycle's request; re-issue required.
- `IdStall`  in  1  decode cannot accept a new IF/ID entry this cycle.
- `Flush`  in  1  redirect (taken branch, jump or SIIC); discard all in-flight fetch state.
- `ImemAddr`  out  16  read address; equals `PC`.
- `ImemRd`  out  1  read request.
- `IfIdInstr`  out  16  registered instruction to decode.
- `IfIdPcInc`  out  16  registered PC+2 of that instruction.
- `IfIdValid`  out  1  IF/ID entry holds a real instruction.
- `PcHold`  out  1  PC block must not advance this cycle.
- `Err`  out  1  misaligned fetch (see Configuration).

## Operation
- FSM states: `REQ`, `WAIT`, `SKID`, `DRAIN`.
- `REQ`:
  - `ImemRd`=1.
  - If `ImemStall`, stay in `REQ`.
  - If `ImemDone` in the same cycle, deliver the instruction and stay in `REQ`.
  - Otherwise go to `WAIT`.
- `WAIT`: `ImemRd`=0. Stay until `ImemDone`, then deliver and return to `REQ`.
- Deliver:
  - If `IfIdValid`=0 or `IdStall`=0: IF/ID loads {`ImemData`, `PC`+2, valid=1}.
  - Otherwise the instruction goes into the skid buffer and the FSM goes to `SKID`.
- `SKID`:
  - `ImemRd`=0.
  - When `IdStall`=0, the skid entry moves into IF/ID and the FSM goes to `REQ`.
- `DRAIN`: entered on `Flush` while in `WAIT`. Waits for `ImemDone`, discards the data, then goes to `REQ`.
- `Flush` in any other state:
  - IF/ID loads {`NOP_INSTR`, 0, valid=0}.
  - Skid buffer is cleared.
  - Next state is `REQ`.
  - `Flush` overrides `IdStall` and `ImemDone` in the same cycle.
- When `IdStall`=1 and no delivery occurs, IF/ID holds its value.
- `PcHold`=0 only in the cycle where a delivery loads IF/ID or the skid buffer without `Flush`. It is 1 in all other cycles, including every cycle of `SKID` and `DRAIN`.
- `IfIdPcInc` = (`PC`+2) mod 2^16. 16'hFFFE wraps to 16'h0000.

## Timing
- Reset values:
  - State `REQ`.
  - `IfIdInstr`=`NOP_INSTR`, `IfIdPcInc`=0, `IfIdValid`=0.
  - Skid buffer empty, `Err`=0.
  - `ImemRd`=0 and `PcHold`=1 while `rst` is high.
- Reset asserted mid-fetch abandons the request; no `DRAIN` is performed.
- Single-cycle memory (`ImemDone` same cycle as `ImemRd`): one instruction per cycle; IF/ID valid on the edge after the request.
- N-cycle memory: IF/ID updates on the edge after `ImemDone`. `PcHold`=1 for N-1 cycles.
- `ImemAddr`, `ImemRd` and `PcHold` are combinational from state and inputs. All IF/ID outputs are registered.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - In `REQ`, `PC[0]`=1 suppresses `ImemRd` and sets sticky `Err`=1, cleared only by `rst`.
  - IF/ID loads a bubble and `PcHold` stays 1.
- Undefined: `Err` is tied 0 and `PC[0]` is passed through to memory unchecked.

## Structure
- `fetch_pkg` holds the FSM state enum, the `NOP_INSTR` default and a 16-bit instruction typedef. Shared with decode.
- One sub-module, `fetch_skid`: a one-entry {instr, pcinc} buffer with load, unload and clear controls and asynchronous reset.

## Test plan
- Reset release, single-cycle memory, `PC`=0,2,4: IF/ID shows the three instructions on consecutive cycles with `IfIdPcInc`=2,4,6 and `PcHold`=0 throughout.
- 3-cycle memory at `PC`=16'h0010 returning 16'h1234: `PcHold`=1 for 2 cycles; then `IfIdInstr`=16'h1234 and `IfIdPcInc`=16'h0012.
- `IdStall` high for 3 cycles while a fetch completes: the instruction is held in `SKID` with `PcHold`=1. After the stall drops it reaches IF/ID exactly once, with no duplicate or lost instruction.
- `Flush` during `WAIT`: the late `ImemDone` data (16'hDEAD) never appears in IF/ID, and `IfIdValid`=0 with `IfIdInstr`=16'h0800.
- `PC`=16'hFFFE: `IfIdPcInc`=16'h0000.
- `PC`=16'h0003 with `FETCH_ALIGN_CHK_EN` defined: `ImemRd`=0, `Err` goes to 1 and stays 1 until `rst`.
